// File: rtl/sar_ctrl.sv
// Successive-approximation controller: track/hold sequencing and binary search.
// Define SAR_CTRL_BACK_TO_BACK_EN to chain conversions without an idle cycle.
module sar_ctrl #(
    parameter int NBIT          = 8,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            comp_out,
    output logic            sample,
    output logic            comp_en,
    output logic [NBIT-1:0] dac_code,
    output logic [NBIT-1:0] dout,
    output logic            valid,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONV
    } state_t;

    localparam logic [NBIT-1:0] MSB = NBIT'(1) << (NBIT - 1);
    localparam logic [3:0] CNT_LAST = 4'(SAMPLE_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NBIT-1:0] bit_q, bit_d;
    logic [NBIT-1:0] dac_q, dac_d;
    logic [NBIT-1:0] dout_q, dout_d;
    logic [NBIT-1:0] code;
    logic            sample_q, sample_d;
    logic            comp_en_q, comp_en_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            dac_q     <= '0;
            dout_q    <= '0;
            sample_q  <= 1'b0;
            comp_en_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            dac_q     <= dac_d;
            dout_q    <= dout_d;
            sample_q  <= sample_d;
            comp_en_q <= comp_en_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // bit_q is a one-hot pointer to the bit under trial
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        dac_d     = dac_q;
        dout_d    = dout_q;
        sample_d  = sample_q;
        comp_en_d = comp_en_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        code      = dac_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SAMPLE;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            SAMPLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d   = CONV;
                    sample_d  = 1'b0;
                    comp_en_d = 1'b1;
                    dac_d     = MSB;
                    bit_d     = MSB;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CONV: begin
                if (!comp_out) begin
                    code = code & ~bit_q;
                end
                if (bit_q[0]) begin
                    dac_d     = code;
                    dout_d    = code;
                    valid_d   = 1'b1;
                    comp_en_d = 1'b0;
                    busy_d    = 1'b0;
                    bit_d     = '0;
                    state_d   = IDLE;
`ifdef SAR_CTRL_BACK_TO_BACK_EN
                    if (start) begin
                        state_d  = SAMPLE;
                        sample_d = 1'b1;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                    end
`endif
                end else begin
                    dac_d = code | (bit_q >> 1);
                    bit_d = bit_q >> 1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sample   = sample_q;
    assign comp_en  = comp_en_q;
    assign dac_code = dac_q;
    assign dout     = dout_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl with an ideal comparator (target >= dac_code).
// Back-to-back checks are selected when SAR_CTRL_BACK_TO_BACK_EN is defined.
module tb_sar_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       comp_out;
    logic       sample;
    logic       comp_en;
    logic [7:0] dac_code;
    logic [7:0] dout;
    logic       valid;
    logic       busy;
    logic [7:0] target = 8'h00;
    logic [7:0] seq [8];

    int n_checks = 0;
    int n_fail   = 0;

    sar_ctrl #(
        .NBIT(8),
        .SAMPLE_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .comp_out(comp_out),
        .sample(sample),
        .comp_en(comp_en),
        .dac_code(dac_code),
        .dout(dout),
        .valid(valid),
        .busy(busy)
    );

    assign comp_out = (target >= dac_code);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic convert(input logic [7:0] t);
        target = t;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("cv_busy", busy, 1);
        for (int k = 1; k < 10; k++) begin
            tick();
            chk("cv_novalid", valid, 0);
        end
        tick();
        chk("cv_valid", valid, 1);
        chk("cv_dout", dout, t);
        chk("cv_idle", busy, 0);
        tick();
        chk("cv_pulse", valid, 0);
    endtask

    initial begin
        seq = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        tick();
        tick();
        chk("rst_sample", sample, 0);
        chk("rst_comp_en", comp_en, 0);
        chk("rst_dac", dac_code, 0);
        chk("rst_dout", dout, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // basic conversion of 0xA5
        target = 8'hA5;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("e0_sample", sample, 1);
        chk("e0_busy", busy, 1);
        chk("e0_comp_en", comp_en, 0);
        tick();
        chk("e1_sample", sample, 1);
        tick();
        chk("e2_sample", sample, 0);
        chk("e2_comp_en", comp_en, 1);
        chk("e2_dac", dac_code, seq[0]);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("seq_dac", dac_code, seq[k]);
            chk("seq_novalid", valid, 0);
        end
        tick();
        chk("a5_valid", valid, 1);
        chk("a5_dout", dout, 8'hA5);
        chk("a5_busy", busy, 0);
        chk("a5_comp_en", comp_en, 0);
        chk("a5_dac_hold", dac_code, 8'hA5);
        tick();
        chk("a5_pulse", valid, 0);
        chk("a5_hold", dout, 8'hA5);

        convert(8'h00);
        convert(8'hFF);

        // start held through a conversion
        target = 8'h5A;
        start  = 1'b1;
        tick();
        for (int k = 1; k < 10; k++) begin
            tick();
            chk("held_busy", busy, 1);
            chk("held_novalid", valid, 0);
        end
        tick();
        chk("held_valid", valid, 1);
        chk("held_dout", dout, 8'h5A);
`ifdef SAR_CTRL_BACK_TO_BACK_EN
        chk("b2b_busy", busy, 1);
        chk("b2b_sample", sample, 1);
        target = 8'h33;
        start  = 1'b0;
`else
        chk("held_idle", busy, 0);
        tick();
        chk("restart_pulse", valid, 0);
        chk("restart_busy", busy, 1);
        chk("restart_sample", sample, 1);
        target = 8'h33;
        start  = 1'b0;
`endif
        for (int k = 1; k < 10; k++) begin
            tick();
            chk("second_novalid", valid, 0);
        end
        tick();
        chk("second_valid", valid, 1);
        chk("second_dout", dout, 8'h33);
        tick();
        chk("second_pulse", valid, 0);

        // asynchronous reset in the middle of the search
        target = 8'hA5;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("mid_dac", dac_code, 8'hA0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_sample", sample, 0);
        chk("arst_comp_en", comp_en, 0);
        chk("arst_dac", dac_code, 0);
        chk("arst_dout", dout, 0);
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        convert(8'hA5);

`ifdef SAR_CTRL_BACK_TO_BACK_EN
        target = 8'h3C;
        start  = 1'b1;
        tick();
        for (int k = 1; k < 10; k++) begin
            tick();
            chk("bb1_busy", busy, 1);
        end
        tick();
        chk("bb1_valid", valid, 1);
        chk("bb1_dout", dout, 8'h3C);
        chk("bb1_busy_hold", busy, 1);
        target = 8'hC3;
        for (int k = 1; k < 10; k++) begin
            tick();
            chk("bb2_novalid", valid, 0);
            chk("bb2_busy", busy, 1);
        end
        tick();
        chk("bb2_valid", valid, 1);
        chk("bb2_dout", dout, 8'hC3);
        start = 1'b0;
        tick();
        chk("bb2_pulse", valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
